// File: rtl/fp_div_pkg.sv
// Shared types, flag positions and width helpers for the sequential FP divider.
package fp_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } fp_div_state_e;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_DIV_ZERO  = 2;
    localparam int FLG_OVERFLOW  = 1;
    localparam int FLG_UNDERFLOW = 0;

    function automatic int word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Remainder needs one bit above the divisor mantissa to hold 2*rem before compare.
    function automatic int rem_w(input int man_w);
        return man_w + 2;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_div_classify.sv
// Splits one operand into fields and classifies it; denormals read as zero.
module fp_div_classify
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = word_w(EXP_W, MAN_W)
) (
    input  logic [W-1:0]     operand,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W:0]   mant
);

    logic [MAN_W-1:0] frac;
    logic             exp_max;

    assign sign    = operand[W-1];
    assign exp     = operand[W-2:MAN_W];
    assign frac    = operand[MAN_W-1:0];
    assign exp_max = &exp;
    assign is_zero = (exp == '0);
    assign is_inf  = exp_max && (frac == '0);
    assign is_nan  = exp_max && (frac != '0);
    assign mant    = {1'b1, frac};

endmodule

// File: rtl/fp_div_seq.sv
// Sequential restoring floating-point divider, one quotient bit per cycle,
// round-to-nearest-even, flush-to-zero, one operation in flight.
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = word_w(EXP_W, MAN_W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [3:0]   flags
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] CALC = ST_CALC;
    localparam logic [1:0] NORM = ST_NORM;
    localparam logic [1:0] DONE = ST_DONE;

    localparam int RW    = rem_w(MAN_W);
    localparam int QW    = MAN_W + 3;
    localparam int EW    = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 4);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MAN_W + 3);
    localparam logic [EW-1:0]    BIAS_E   = EW'(bias_of(EXP_W));
    localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);
    localparam logic [63:0]      NAN64    = canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN     = NAN64[W-1:0];

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [RW-1:0]    rem;
    logic [MAN_W:0]   mb_q;
    logic [QW-1:0]    q;
    logic [EW-1:0]    e_q;
    logic             sign_q;

    logic             a_zero, a_inf, a_nan, a_sign;
    logic             b_zero, b_inf, b_nan, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W:0]   a_mant, b_mant;

    fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .operand(dividend), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan),
        .sign(a_sign), .exp(a_exp), .mant(a_mant)
    );

    fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .operand(divisor), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan),
        .sign(b_sign), .exp(b_exp), .mant(b_mant)
    );

    logic          sign_ab;
    logic [EW-1:0] e_calc;

    assign sign_ab   = a_sign ^ b_sign;
    assign e_calc    = {2'b00, a_exp} - {2'b00, b_exp} + BIAS_E;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    logic         special;
    logic [W-1:0] spec_word;
    logic [3:0]   spec_flags;

    // Special-operand decode in priority order; these bypass the iteration entirely.
    always_comb begin
        special    = 1'b1;
        spec_word  = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_word = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_word                = QNAN;
            spec_flags[FLG_INVALID]  = 1'b1;
        end else if (!a_inf && !a_zero && b_zero) begin
            spec_word                = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags[FLG_DIV_ZERO] = 1'b1;
        end else if (a_inf) begin
            spec_word = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_inf) begin
            spec_word = {sign_ab, {(W-1){1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    logic          rem_ge;
    logic [RW-1:0] rem_sub;
    logic [RW-1:0] rem_next;

    // One restoring step: compare, conditionally subtract, shift for the next bit.
    always_comb begin
        rem_ge   = (rem >= {1'b0, mb_q});
        rem_sub  = rem_ge ? (rem - {1'b0, mb_q}) : rem;
        rem_next = rem_sub << 1;
    end

    logic [MAN_W:0]   mant;
    logic [MAN_W-1:0] frac_r;
    logic             guard, sticky, round_up, carry, ovf, unf;
    logic [EW-1:0]    e_norm;
    logic [W-1:0]     norm_word;
    logic [3:0]       norm_flags;

    // Normalise by at most one place, round to nearest even, then range-check the exponent.
    always_comb begin
        mant      = q[QW-1] ? q[QW-1:2] : q[QW-2:1];
        guard     = q[QW-1] ? q[1] : q[0];
        sticky    = (q[QW-1] & q[0]) | (rem != '0);
        round_up  = guard & (sticky | mant[0]);
        frac_r    = mant[MAN_W-1:0] + MAN_W'(round_up);
        carry     = round_up & (&mant);
        e_norm    = e_q - EW'(!q[QW-1]) + EW'(carry);
        ovf       = ($signed(e_norm) >= $signed(EMAX));
        unf       = e_norm[EW-1] || (e_norm == '0);
        norm_flags = '0;
        if (ovf) begin
            norm_word                = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_flags[FLG_OVERFLOW] = 1'b1;
        end else if (unf) begin
            norm_word                 = {sign_q, {(W-1){1'b0}}};
            norm_flags[FLG_UNDERFLOW] = 1'b1;
        end else begin
            norm_word = {sign_q, e_norm[EXP_W-1:0], frac_r};
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            mb_q     <= '0;
            q        <= '0;
            e_q      <= '0;
            sign_q   <= 1'b0;
            quotient <= '0;
            flags    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (special) begin
                            quotient <= spec_word;
                            flags    <= spec_flags;
                            state    <= DONE;
                        end else begin
                            rem    <= {1'b0, a_mant};
                            mb_q   <= b_mant;
                            q      <= '0;
                            e_q    <= e_calc;
                            sign_q <= sign_ab;
                            cnt    <= CNT_INIT;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    q   <= {q[QW-2:0], rem_ge};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= NORM;
                end
                NORM: begin
                    quotient <= norm_word;
                    flags    <= norm_flags;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed-vector bench for fp_div_seq: single and half precision instances.
module tb_fp_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] dividend, divisor, quotient;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_dividend, h_divisor, h_quotient;
    logic [3:0]  h_flags;

    int n_checks = 0;
    int n_fail   = 0;
    int edges;

    fp_div_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .flags(flags)
    );

    fp_div_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .dividend(h_dividend), .divisor(h_divisor), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .quotient(h_quotient), .flags(h_flags)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q_exp, input logic [3:0] f_exp, input int lat_exp);
        int n;
        check_eq({tag, " ready"}, in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, " latency"}, n, lat_exp);
        check_eq({tag, " quotient"}, quotient, q_exp);
        check_eq({tag, " flags"}, flags, f_exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq({tag, " release"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b0; h_dividend = '0; h_divisor = '0;
        repeat (3) step();
        rst = 1'b0;
        check_eq("rst in_ready", in_ready, 1);
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst quotient", quotient, 0);
        check_eq("rst flags", flags, 0);

        run_op("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
        run_op("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);
        run_op("-6/2",     32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28);
        run_op("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
        run_op("0/0",      32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
        run_op("nan/1",    32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b0000, 1);
        run_op("inf/2",    32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 1);
        run_op("2/-inf",   32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 1);
        run_op("ovf",      32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 28);
        run_op("unf",      32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 28);

        // Stall with in_valid held high and new operands presented while busy.
        dividend = 32'h40C00000; divisor = 32'h40000000; in_valid = 1'b1;
        step();
        dividend = 32'h3F800000; divisor = 32'h40400000;
        edges = 1;
        while (!out_valid && edges < 200) begin
            step();
            edges++;
        end
        check_eq("stall latency", edges, 28);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("stall quotient", quotient, 32'h40400000);
            check_eq("stall in_ready", in_ready, 0);
            check_eq("stall out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("no same-cycle accept", {in_ready, out_valid}, 2'b10);
        step();
        in_valid = 1'b0;
        check_eq("queued accept", in_ready, 0);
        edges = 1;
        while (!out_valid && edges < 200) begin
            step();
            edges++;
        end
        check_eq("queued latency", edges, 28);
        check_eq("queued quotient", quotient, 32'h3EAAAAAB);
        check_eq("queued flags", flags, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Abort mid-iteration.
        dividend = 32'h40C00000; divisor = 32'h40000000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort in_ready", in_ready, 1);
        check_eq("abort out_valid", out_valid, 0);
        run_op("post-abort 6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);

        // Half precision instance.
        h_dividend = 16'h4600; h_divisor = 16'h4000; h_in_valid = 1'b1;
        step();
        h_in_valid = 1'b0;
        edges = 1;
        while (!h_out_valid && edges < 200) begin
            step();
            edges++;
        end
        check_eq("half latency", edges, 15);
        check_eq("half quotient", h_quotient, 16'h4200);
        check_eq("half flags", h_flags, 0);
        h_out_ready = 1'b1;
        step();
        h_out_ready = 1'b0;
        check_eq("half release", {h_in_ready, h_out_valid}, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Parametrised sequential IEEE-754-style floating-point divider with valid/ready handshakes, round-to-nearest-even and special-case handling. It replaces the fixed 32-bit, free-running divider: any exponent/mantissa split, one operation in flight, a proper normalisation/rounding step and exception flags. It sits in the FP datapath next to the adder/multiplier and is fed by an upstream operand queue.

## Interface

- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width (hidden bit excluded); word width W = 1+EXP_W+MAN_W
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- dividend  in  W  {sign, exponent, fraction}
- divisor  in  W  same format
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- quotient  out  W  result
- flags  out  4  {invalid, div_by_zero, overflow, underflow}, valid with out_valid

## Operation

- FSM states: IDLE, CALC, NORM, DONE. in_ready = (state==IDLE). Accept on in_valid && in_ready; operands are registered.
- Classify each operand: zero (exp==0, any fraction; denormals flush to zero), inf (exp all-ones, frac==0), NaN (exp all-ones, frac!=0), normal.
- Special cases (IDLE -> DONE directly), in priority order. Sign = sign_a ^ sign_b except for NaN.
  - Any NaN operand -> canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0), flags 0.
  - 0/0 or inf/inf -> canonical qNaN, invalid=1.
  - finite nonzero / 0 -> signed inf, div_by_zero=1.
  - inf/finite -> signed inf.
  - 0/x or finite/inf -> signed zero.
- Normal path: IDLE -> CALC. Mantissas ma, mb = {1, frac}, MAN_W+1 bits each. Restoring division, one quotient bit per cycle, MAN_W+3 bits total. rem starts at ma. Each step: qbit = (rem >= mb); if set, rem -= mb; then rem <<= 1. Rem register is MAN_W+2 bits.
- NORM, one cycle:
  - If q MSB == 0: shift q left 1 and decrement the exponent.
  - Keep 1+MAN_W bits plus a guard bit; sticky = (rem != 0).
  - Round to nearest, ties to even.
  - If rounding carries out, re-normalise and increment the exponent.
- Exponent: e = ea - eb + bias, computed signed in EXP_W+2 bits.
  - If e >= 2^EXP_W-1 -> signed inf, overflow=1.
  - If e <= 0 -> signed zero, underflow=1 (flush to zero, no denormal output).
- DONE: out_valid=1. quotient and flags are stable until out_ready is sampled high, then DONE -> IDLE.

## Timing

- Reset values: state IDLE, in_ready=1, out_valid=0, quotient=0, flags=0. rst in any state aborts the operation with no output.
- Normal latency: out_valid is first high after the (MAN_W+5)th rising edge counted from the accepting edge. That is 28 edges at default parameters: 1 edge enters CALC, MAN_W+3 CALC edges, 1 NORM edge.
- Special-case latency: out_valid is high after the edge following acceptance.
- in_ready rises on the edge where the DONE handshake completes. There is no same-cycle accept of a new operation in that cycle. Maximum throughput is 1 op per MAN_W+6 cycles.
- While busy, in_valid and operand changes are ignored.
- out_ready high before out_valid has no effect. out_ready held low stalls indefinitely with outputs frozen.

## Structure

- Package fp_div_pkg holds:
  - state enum
  - flag bit indices
  - width helper functions (W, bias, rem width)
  - canonical-NaN constant function
- Sub-module fp_div_classify: combinational. Takes one operand and outputs is_zero, is_inf, is_nan, sign, exp, mant with the hidden bit. Instantiated twice.
- Iteration counter: $clog2(MAN_W+4) bits.

## Test plan

- 6.0/2.0 (0x40C00000 / 0x40000000) -> 0x40400000, flags 0, out_valid after exactly 28 edges.
- 1.0/3.0 (0x3F800000 / 0x40400000) -> 0x3EAAAAAB (round-up path, sticky set).
- 1.0/0.0 -> 0x7F800000 with div_by_zero. 0/0 -> 0x7FC00000 with invalid. NaN/1.0 -> 0x7FC00000, flags 0. All after 1 edge.
- 0x7F000000 / 0x00800000 -> 0x7F800000 with overflow. 0x00800000 / 0x7F000000 -> 0x00000000 with underflow.
- Hold out_ready low for 10 cycles with in_valid high and new operands applied: quotient stays stable and in_ready stays 0. The next op is accepted only after the handshake.
- Assert rst at CALC cycle 5: next cycle in_ready=1 and out_valid=0. A following 6.0/2.0 completes correctly.
- EXP_W=5, MAN_W=10 (half precision): 0x4600 / 0x4000 (6.0/2.0) -> 0x4200 after 15 edges.
